// File: rtl/frame_tag_insert.sv
// frame_tag_insert: first-node tag insertion.
// Pops a complete raw frame from a show-ahead staging FIFO when its flow-lookup
// result arrives. On a hit it emits a metadata word, swaps the DMAC for the TSN
// tag, forces EtherType 0x1800 and forwards the frame. On a miss it drains the
// frame without output.
module frame_tag_insert #(
  parameter logic [6:0] USEDW_THRESHOLD = 7'd20
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_fifo_empty,
  output logic         o_fifo_rd,
  input  logic [133:0] iv_fifo_data,
  input  logic [56:0]  iv_tsntag_outport,
  input  logic         i_lookup_match_flag,
  input  logic         i_tsntag_outport_wr,
  input  logic [6:0]   iv_fifo_usedw,
  output logic [133:0] ov_pkt_data,
  output logic         o_pkt_data_wr,
  output logic [15:0]  ov_tag_frm_cnt,
  output logic [15:0]  ov_disc_frm_cnt
);

  typedef enum logic [2:0] {IDLE_S, WAIT_S, HEAD_S, TRANS_S, DISC_S} state_t;

  localparam logic [1:0] FLAG_FIRST = 2'b01;
  localparam logic [1:0] FLAG_LAST  = 2'b10;

  state_t      state;
  logic [56:0] rv_tsntag_outport;
  logic [1:0]  flag;
  logic        space_ok;

  assign flag     = iv_fifo_data[133:132];
  assign space_ok = (iv_fifo_usedw <= USEDW_THRESHOLD);

  // Metadata word: flow type = tag[47:45] (bits 56:54 of the lookup result),
  // followed by the 9-bit outport bitmap.
  function automatic logic [133:0] meta_word(input logic [56:0] r);
    return {6'b01_0000, r[56:54], r[8:0], 116'd0};
  endfunction

  // First frame word with DMAC replaced by the TSN tag and EtherType forced.
  function automatic logic [133:0] head_word(input logic [56:0] r, input logic [133:0] d);
    return {2'b11, d[131:128], r[56:9], d[79:32], 16'h1800, d[15:0]};
  endfunction

  // Frame sequencing FSM; all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= IDLE_S;
      o_fifo_rd         <= 1'b0;
      o_pkt_data_wr     <= 1'b0;
      ov_pkt_data       <= '0;
      rv_tsntag_outport <= '0;
      ov_tag_frm_cnt    <= '0;
      ov_disc_frm_cnt   <= '0;
    end else begin
      o_pkt_data_wr <= 1'b0;
      case (state)
        IDLE_S: begin
          if (i_tsntag_outport_wr) begin
            rv_tsntag_outport <= iv_tsntag_outport;
            // A pulse with nothing staged is a protocol violation: ignore it.
            if (!i_fifo_empty) begin
              if (i_lookup_match_flag) begin
                if (space_ok) begin
                  o_pkt_data_wr <= 1'b1;
                  ov_pkt_data   <= meta_word(iv_tsntag_outport);
                  o_fifo_rd     <= 1'b1;
                  state         <= HEAD_S;
                end else begin
                  state <= WAIT_S;
                end
              end else begin
                o_fifo_rd <= 1'b1;
                state     <= DISC_S;
              end
            end
          end
        end
        WAIT_S: begin
          if (space_ok) begin
            o_pkt_data_wr <= 1'b1;
            ov_pkt_data   <= meta_word(rv_tsntag_outport);
            o_fifo_rd     <= 1'b1;
            state         <= HEAD_S;
          end
        end
        HEAD_S: begin
          if (flag == FLAG_FIRST) begin
            o_pkt_data_wr <= 1'b1;
            ov_pkt_data   <= head_word(rv_tsntag_outport, iv_fifo_data);
            state         <= TRANS_S;
          end else if (flag == FLAG_LAST) begin
            // Malformed one-word frame: it is popped on this edge, so stop here
            // instead of draining into the next frame.
            o_fifo_rd <= 1'b0;
            if (ov_disc_frm_cnt != 16'hFFFF) ov_disc_frm_cnt <= ov_disc_frm_cnt + 16'd1;
            state <= IDLE_S;
          end else begin
            state <= DISC_S;
          end
        end
        TRANS_S: begin
          o_pkt_data_wr <= 1'b1;
          ov_pkt_data   <= iv_fifo_data;
          if (flag == FLAG_LAST) begin
            o_fifo_rd <= 1'b0;
            if (ov_tag_frm_cnt != 16'hFFFF) ov_tag_frm_cnt <= ov_tag_frm_cnt + 16'd1;
            state <= IDLE_S;
          end
        end
        DISC_S: begin
          if (flag == FLAG_LAST) begin
            o_fifo_rd <= 1'b0;
            if (ov_disc_frm_cnt != 16'hFFFF) ov_disc_frm_cnt <= ov_disc_frm_cnt + 16'd1;
            state <= IDLE_S;
          end
        end
        default: begin
          o_fifo_rd <= 1'b0;
          state     <= IDLE_S;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tag_insert.sv
// Directed bench for frame_tag_insert with a show-ahead FIFO model feeding it.
module tb_frame_tag_insert;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_fifo_empty;
  logic         o_fifo_rd;
  logic [133:0] iv_fifo_data;
  logic [56:0]  iv_tsntag_outport;
  logic         i_lookup_match_flag;
  logic         i_tsntag_outport_wr;
  logic [6:0]   iv_fifo_usedw;
  logic [133:0] ov_pkt_data;
  logic         o_pkt_data_wr;
  logic [15:0]  ov_tag_frm_cnt;
  logic [15:0]  ov_disc_frm_cnt;

  frame_tag_insert dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_fifo_empty        (i_fifo_empty),
    .o_fifo_rd           (o_fifo_rd),
    .iv_fifo_data        (iv_fifo_data),
    .iv_tsntag_outport   (iv_tsntag_outport),
    .i_lookup_match_flag (i_lookup_match_flag),
    .i_tsntag_outport_wr (i_tsntag_outport_wr),
    .iv_fifo_usedw       (iv_fifo_usedw),
    .ov_pkt_data         (ov_pkt_data),
    .o_pkt_data_wr       (o_pkt_data_wr),
    .ov_tag_frm_cnt      (ov_tag_frm_cnt),
    .ov_disc_frm_cnt     (ov_disc_frm_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Hand-built frames: {flag, byte-valid, DMAC, SMAC, EtherType, 16 more bits}
  localparam logic [133:0] A1    = {2'b01, 4'h0, 48'h001122334455, 48'h66778899AABB, 16'h0800, 16'h4500};
  localparam logic [133:0] A1MOD = {2'b11, 4'h0, 48'h0123456789AB, 48'h66778899AABB, 16'h1800, 16'h4500};
  localparam logic [133:0] A2    = {2'b11, 4'h0, 128'h0102030405060708090A0B0C0D0E0F10};
  localparam logic [133:0] A3    = {2'b11, 4'h0, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0};
  localparam logic [133:0] A4    = {2'b10, 4'hA, 128'h55555555_AAAAAAAA_00000000_FFFFFFFF};
  localparam logic [133:0] MA    = {6'b010000, 3'h0, 9'h003, 116'd0};

  localparam logic [133:0] C1    = {2'b01, 4'h0, 48'hAAAAAAAAAAAA, 48'h020000000002, 16'h86DD, 16'h6000};
  localparam logic [133:0] C1MOD = {2'b11, 4'h0, 48'hE00000000001, 48'h020000000002, 16'h1800, 16'h6000};
  localparam logic [133:0] C2    = {2'b11, 4'h0, 128'h11111111_22222222_33333333_44444444};
  localparam logic [133:0] C3    = {2'b10, 4'h3, 128'h99999999_88888888_77777777_66666666};
  localparam logic [133:0] MC    = {6'b010000, 3'h7, 9'h1FF, 116'd0};

  localparam logic [133:0] MD    = {6'b010000, 3'h1, 9'h010, 116'd0};
  localparam logic [133:0] MID   = {2'b11, 4'h0, 128'h0};
  localparam logic [133:0] LAST  = {2'b10, 4'h0, 128'hFEEDFACE};

  // Show-ahead staging FIFO model; head refreshes just after each edge.
  logic [133:0] q[$];
  int pops = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic refresh();
    i_fifo_empty = (q.size() == 0);
    iv_fifo_data = (q.size() > 0) ? q[0] : '0;
  endtask

  // Consume the head word on each edge with o_fifo_rd high.
  always @(posedge i_clk) begin
    if (o_fifo_rd && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    #1 refresh();
  end

  task automatic push(input logic [133:0] w);
    q.push_back(w);
    refresh();
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One-cycle lookup pulse; returns at the negedge after the consuming edge.
  task automatic pulse(input logic hit, input logic [47:0] tag, input logic [8:0] port);
    i_tsntag_outport_wr = 1'b1;
    i_lookup_match_flag = hit;
    iv_tsntag_outport   = {tag, port};
    @(negedge i_clk);
    i_tsntag_outport_wr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [133:0] obs, input logic [133:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  initial begin
    int p0;
    int nwr;
    i_rst = 1'b1;
    i_tsntag_outport_wr = 1'b0;
    i_lookup_match_flag = 1'b0;
    iv_tsntag_outport = '0;
    iv_fifo_usedw = 7'd5;
    refresh();
    repeat (3) tick();
    chk("rst_rd",   134'(o_fifo_rd), 134'd0);
    chk("rst_wr",   134'(o_pkt_data_wr), 134'd0);
    chk("rst_data", ov_pkt_data, 134'd0);
    chk("rst_tag",  134'(ov_tag_frm_cnt), 134'd0);
    chk("rst_disc", 134'(ov_disc_frm_cnt), 134'd0);
    i_rst = 1'b0;
    tick();

    // Lookup pulse with empty staging FIFO: no reaction
    pulse(1'b1, 48'h0123456789AB, 9'h003);
    chk("empty_wr", 134'(o_pkt_data_wr), 134'd0);
    chk("empty_rd", 134'(o_fifo_rd), 134'd0);
    tick();

    // Hit, 4-word frame
    push(A1); push(A2); push(A3); push(A4);
    p0 = pops;
    pulse(1'b1, 48'h0123456789AB, 9'h003);
    chk("hit_meta_wr", 134'(o_pkt_data_wr), 134'd1);
    chk("hit_meta", ov_pkt_data, MA);
    tick(); chk("hit_w1", ov_pkt_data, A1MOD);
    tick(); chk("hit_w2", ov_pkt_data, A2);
    tick(); chk("hit_w3", ov_pkt_data, A3);
    tick(); chk("hit_w4", ov_pkt_data, A4);
    chk("hit_w4_wr", 134'(o_pkt_data_wr), 134'd1);
    chk("hit_tagcnt", 134'(ov_tag_frm_cnt), 134'd1);
    chk("hit_pops", 134'(pops - p0), 134'd4);
    tick(); chk("hit_idle_wr", 134'(o_pkt_data_wr), 134'd0);

    // Miss, 6-word frame
    push(A1); push(MID); push(MID); push(MID); push(MID); push(LAST);
    p0 = pops;
    pulse(1'b0, 48'h0, 9'h0);
    nwr = int'(o_pkt_data_wr);
    repeat (8) begin tick(); nwr += int'(o_pkt_data_wr); end
    chk("miss_nowr", 134'(nwr), 134'd0);
    chk("miss_pops", 134'(pops - p0), 134'd6);
    chk("miss_disc", 134'(ov_disc_frm_cnt), 134'd1);
    chk("miss_rd", 134'(o_fifo_rd), 134'd0);

    // Backpressure: wait above threshold, release at exactly the threshold
    iv_fifo_usedw = 7'd25;
    push(C1); push(C2); push(C3);
    p0 = pops;
    pulse(1'b1, 48'hE00000000001, 9'h1FF);
    nwr = int'(o_pkt_data_wr);
    repeat (5) begin tick(); nwr += int'(o_pkt_data_wr); end
    chk("bp_nowr", 134'(nwr), 134'd0);
    chk("bp_nopop", 134'(pops - p0), 134'd0);
    iv_fifo_usedw = 7'd20;
    tick(); chk("bp_meta", ov_pkt_data, MC);
    chk("bp_meta_wr", 134'(o_pkt_data_wr), 134'd1);
    tick(); chk("bp_w1", ov_pkt_data, C1MOD);
    tick(); chk("bp_w2", ov_pkt_data, C2);
    tick(); chk("bp_w3", ov_pkt_data, C3);
    chk("bp_tagcnt", 134'(ov_tag_frm_cnt), 134'd2);
    iv_fifo_usedw = 7'd5;
    tick();

    // Bad head flag: metadata only, then frame discarded
    push(MID); push(MID); push(LAST);
    p0 = pops;
    pulse(1'b1, 48'h200000000000, 9'h010);
    chk("bad_meta", ov_pkt_data, MD);
    nwr = 0;
    repeat (5) begin tick(); nwr += int'(o_pkt_data_wr); end
    chk("bad_nowr", 134'(nwr), 134'd0);
    chk("bad_pops", 134'(pops - p0), 134'd3);
    chk("bad_disc", 134'(ov_disc_frm_cnt), 134'd2);
    chk("bad_tag", 134'(ov_tag_frm_cnt), 134'd2);

    // Lookup pulse during TRANS_S must be ignored
    push(A1); push(A2); push(A3); push(A4); push(A1); push(LAST);
    pulse(1'b1, 48'h0123456789AB, 9'h003);
    chk("ign_meta", ov_pkt_data, MA);
    tick(); chk("ign_w1", ov_pkt_data, A1MOD);
    i_tsntag_outport_wr = 1'b1;
    i_lookup_match_flag = 1'b0;
    tick();
    i_tsntag_outport_wr = 1'b0;
    chk("ign_w2", ov_pkt_data, A2);
    tick(); chk("ign_w3", ov_pkt_data, A3);
    tick(); chk("ign_w4", ov_pkt_data, A4);
    tick(); tick();
    chk("ign_left", 134'(q.size()), 134'd2);
    chk("ign_disc", 134'(ov_disc_frm_cnt), 134'd2);
    chk("ign_tag", 134'(ov_tag_frm_cnt), 134'd3);
    pulse(1'b0, 48'h0, 9'h0);
    repeat (4) tick();
    chk("ign_drain", 134'(ov_disc_frm_cnt), 134'd3);

    // Reset during word 2, then a fresh frame
    push(A1); push(A2); push(A3); push(A4);
    pulse(1'b1, 48'h0123456789AB, 9'h003);
    tick(); chk("rm_w1", ov_pkt_data, A1MOD);
    tick(); chk("rm_w2", ov_pkt_data, A2);
    i_rst = 1'b1;
    tick();
    chk("rm_rd",   134'(o_fifo_rd), 134'd0);
    chk("rm_wr",   134'(o_pkt_data_wr), 134'd0);
    chk("rm_data", ov_pkt_data, 134'd0);
    chk("rm_tag",  134'(ov_tag_frm_cnt), 134'd0);
    chk("rm_disc", 134'(ov_disc_frm_cnt), 134'd0);
    i_rst = 1'b0;
    q.delete();
    refresh();
    tick();
    push(A1); push(LAST);
    pulse(1'b1, 48'h0123456789AB, 9'h003);
    chk("rm2_meta", ov_pkt_data, MA);
    tick(); chk("rm2_w1", ov_pkt_data, A1MOD);
    tick(); chk("rm2_w2", ov_pkt_data, LAST);
    chk("rm2_tag", 134'(ov_tag_frm_cnt), 134'd1);
    tick();

    // Saturation of the tagged-frame counter
    force dut.ov_tag_frm_cnt = 16'hFFFE;
    #1;
    release dut.ov_tag_frm_cnt;
    @(negedge i_clk);
    chk("sat_preload", 134'(ov_tag_frm_cnt), 134'hFFFE);
    for (int k = 0; k < 3; k++) begin
      push(A1); push(LAST);
      pulse(1'b1, 48'h0123456789AB, 9'h003);
      tick(); tick(); tick();
      chk("sat_cnt", 134'(ov_tag_frm_cnt), 134'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
